// File: rtl/adc_capture_buffer.sv
// ============================================================================
//  Module      : adc_capture_buffer
//  Description : Triggered ADC sample capture into a 2^ADDR_W buffer with a
//                2-cycle scaled read port feeding a scope-style plot drawer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_capture_buffer #(
    parameter int ADDR_W  = 11,
    parameter int ROWS    = 120,
    parameter int TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              adc_valid,
    input  logic [13:0]       adc_data,
    input  logic [13:0]       trigger_level,
    input  logic              arm,
    input  logic              read_busy,
    input  logic [ADDR_W-1:0] read_CounterX,
    output logic [7:0]        CounterY,
    output logic              capture_done,
    output logic              forced_trig
);

    localparam int              c_TMO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0]  c_ADDR_LAST = '1;
    localparam logic [13:0]        c_ROW_MAX   = 14'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        READY   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [ADDR_W-1:0]    r_wr_addr;
    logic [c_TMO_W-1:0]   r_tmo_cnt;
    logic [13:0]          r_prev_sample;
    logic                 r_done;
    logic                 r_forced;

    logic                 w_level_hit;
    logic                 w_tmo_hit;
    logic                 w_trig;
    logic                 w_we;
    logic [ADDR_W-1:0]    w_waddr;

    logic [13:0]          r_mem [0:(1<<ADDR_W)-1];
    logic [13:0]          r_rd_data;
    logic [13:0]          w_rd_hi;
    logic [13:0]          w_row;

    assign w_level_hit = (r_prev_sample < trigger_level) && (adc_data >= trigger_level);
    assign w_tmo_hit   = (r_tmo_cnt == c_TMO_LAST);

    always_comb begin
        w_next_state = r_state;
        w_trig       = 1'b0;
        w_we         = 1'b0;
        w_waddr      = r_wr_addr;
        case (r_state)
            IDLE, READY: begin
                if (arm && !read_busy) begin
                    w_next_state = ARMED;
                end
            end
            ARMED: begin
                if (adc_valid && (w_level_hit || w_tmo_hit)) begin
                    w_trig       = 1'b1;
                    w_we         = 1'b1;
                    w_waddr      = '0;
                    w_next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                if (adc_valid) begin
                    w_we = 1'b1;
                    if (r_wr_addr == c_ADDR_LAST) begin
                        w_next_state = READY;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_wr_addr     <= '0;
            r_tmo_cnt     <= '0;
            r_prev_sample <= '0;
            r_done        <= 1'b0;
            r_forced      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= (w_next_state == READY);
            if (adc_valid) begin
                r_prev_sample <= adc_data;
            end
            if (w_next_state == ARMED && r_state != ARMED) begin
                r_tmo_cnt <= '0;
            end else if (r_state == ARMED && adc_valid) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            // A level crossing wins over a coincident timeout.
            if (w_trig) begin
                r_wr_addr <= ADDR_W'(1);
                r_forced  <= w_tmo_hit && !w_level_hit;
            end else if (w_we) begin
                r_wr_addr <= r_wr_addr + 1'b1;
            end
        end
    end

    // Buffer storage is deliberately not reset; a read of the written address
    // in the same cycle returns the previous contents.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= adc_data;
        end
        r_rd_data <= r_mem[read_CounterX];
    end

    assign w_rd_hi = r_rd_data >> 7;
    assign w_row   = (w_rd_hi > c_ROW_MAX) ? c_ROW_MAX : w_rd_hi;

    always_ff @(posedge clk) begin
        if (reset) begin
            CounterY <= '0;
        end else begin
            CounterY <= 8'(c_ROW_MAX - w_row);
        end
    end

    assign capture_done = r_done;
    assign forced_trig  = r_forced;

endmodule

`default_nettype wire

// File: tb/tb_adc_capture_buffer.sv
// ============================================================================
//  Module      : tb_adc_capture_buffer
//  Description : Directed self-checking bench for adc_capture_buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adc_capture_buffer;

    localparam int c_TMO   = 1000;
    localparam int c_DEPTH = 2048;

    logic        clk;
    logic        reset;
    logic        adc_valid;
    logic [13:0] adc_data;
    logic [13:0] trigger_level;
    logic        arm;
    logic        read_busy;
    logic [10:0] read_CounterX;
    logic [7:0]  CounterY;
    logic        capture_done;
    logic        forced_trig;

    int n_vec;
    int n_err;
    int exp_mem [0:c_DEPTH-1];

    adc_capture_buffer #(
        .ADDR_W  (11),
        .ROWS    (120),
        .TIMEOUT (c_TMO)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .adc_valid     (adc_valid),
        .adc_data      (adc_data),
        .trigger_level (trigger_level),
        .arm           (arm),
        .read_busy     (read_busy),
        .read_CounterX (read_CounterX),
        .CounterY      (CounterY),
        .capture_done  (capture_done),
        .forced_trig   (forced_trig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] row_of(input int v);
        int y;
        y = v >> 7;
        if (y > 119) y = 119;
        return 8'(119 - y);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        adc_valid = 1'b1;
        adc_data  = 14'(v);
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic read_check(input int addr, input logic [7:0] expv);
        read_CounterX = 11'(addr);
        tick();
        tick();
        n_vec++;
        if (CounterY !== expv) begin
            n_err++;
            $display("FAIL read_addr%0d: CounterY=%0d expected %0d", addr, CounterY, expv);
        end
    endtask

    task automatic sweep_check(input string tag);
        for (int k = 0; k <= c_DEPTH; k++) begin
            if (k < c_DEPTH) read_CounterX = 11'(k);
            tick();
            if (k >= 1) begin
                n_vec++;
                if (CounterY !== row_of(exp_mem[k-1])) begin
                    n_err++;
                    $display("FAIL %s_sweep addr %0d: CounterY=%0d expected %0d",
                             tag, k - 1, CounterY, row_of(exp_mem[k-1]));
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_vec++;
        if (CounterY !== 8'd0) begin
            n_err++; $display("FAIL reset_CounterY: got %0d expected 0", CounterY);
        end
        n_vec++;
        if (capture_done !== 1'b0) begin
            n_err++; $display("FAIL reset_done: got %0b expected 0", capture_done);
        end
        n_vec++;
        if (forced_trig !== 1'b0) begin
            n_err++; $display("FAIL reset_forced: got %0b expected 0", forced_trig);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_level_trigger();
        trigger_level = 14'd8192;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        send(8000);
        send(8100);
        send(8300);
        exp_mem[0] = 8300;
        for (int k = 1; k < c_DEPTH - 1; k++) begin
            send(8300 + k);
            exp_mem[k] = 8300 + k;
        end
        n_vec++;
        if (capture_done !== 1'b0) begin
            n_err++; $display("FAIL level_done_early: got %0b expected 0", capture_done);
        end
        send(8300 + c_DEPTH - 1);
        exp_mem[c_DEPTH-1] = 8300 + c_DEPTH - 1;
        n_vec++;
        if (capture_done !== 1'b1) begin
            n_err++; $display("FAIL level_done: got %0b expected 1", capture_done);
        end
        n_vec++;
        if (forced_trig !== 1'b0) begin
            n_err++; $display("FAIL level_forced: got %0b expected 0", forced_trig);
        end
        read_check(0, 8'd55);
        sweep_check("ramp");
    endtask

    task automatic test_arm_blocked();
        read_busy = 1'b1;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        tick();
        tick();
        n_vec++;
        if (capture_done !== 1'b1) begin
            n_err++; $display("FAIL busy_arm_done: got %0b expected 1", capture_done);
        end
        send(9000);
        read_check(0, 8'd55);
        read_busy = 1'b0;
        tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        n_vec++;
        if (capture_done !== 1'b0) begin
            n_err++; $display("FAIL rearm_done: got %0b expected 0", capture_done);
        end
    endtask

    task automatic test_timeout();
        trigger_level = 14'd8192;
        for (int i = 1; i < c_TMO; i++) send(100);
        n_vec++;
        if (forced_trig !== 1'b0) begin
            n_err++; $display("FAIL tmo_forced_early: got %0b expected 0", forced_trig);
        end
        send(100);
        n_vec++;
        if (forced_trig !== 1'b1) begin
            n_err++; $display("FAIL tmo_forced: got %0b expected 1", forced_trig);
        end
        for (int k = 1; k < c_DEPTH; k++) send(100);
        n_vec++;
        if (capture_done !== 1'b1) begin
            n_err++; $display("FAIL tmo_done: got %0b expected 1", capture_done);
        end
        read_check(0, 8'd119);
        read_check(2047, 8'd119);
    endtask

    task automatic test_simultaneous();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 1; i < c_TMO; i++) send(100);
        n_vec++;
        if (forced_trig !== 1'b1) begin
            n_err++; $display("FAIL simul_forced_hold: got %0b expected 1", forced_trig);
        end
        send(9000);
        n_vec++;
        if (forced_trig !== 1'b0) begin
            n_err++; $display("FAIL simul_forced: got %0b expected 0", forced_trig);
        end
        for (int k = 1; k < 1000; k++) send(200);
    endtask

    task automatic test_reset_mid_capture();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++;
        if (capture_done !== 1'b0) begin
            n_err++; $display("FAIL midcap_done: got %0b expected 0", capture_done);
        end
        for (int k = 0; k < 1100; k++) send(300);
        n_vec++;
        if (capture_done !== 1'b0) begin
            n_err++; $display("FAIL midcap_idle_done: got %0b expected 0", capture_done);
        end
    endtask

    task automatic test_gapped();
        int v;
        trigger_level = 14'd1;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        send(0);
        for (int k = 0; k < c_DEPTH; k++) begin
            v = (k == 5) ? 16383 : (k == 6) ? 0 : 8 * k + 4;
            exp_mem[k] = v;
            if (k == c_DEPTH - 1) begin
                n_vec++;
                if (capture_done !== 1'b0) begin
                    n_err++; $display("FAIL gap_done_early: got %0b expected 0", capture_done);
                end
            end
            send(v);
            arm = (k == 1000);
            tick();
            arm = 1'b0;
            tick();
        end
        n_vec++;
        if (capture_done !== 1'b1) begin
            n_err++; $display("FAIL gap_done: got %0b expected 1", capture_done);
        end
        n_vec++;
        if (forced_trig !== 1'b0) begin
            n_err++; $display("FAIL gap_forced: got %0b expected 0", forced_trig);
        end
        read_check(5, 8'd0);
        read_check(6, 8'd119);
        read_check(0, 8'd119);
        read_check(2047, 8'd0);
        sweep_check("gap");
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec         = 0;
        n_err         = 0;
        reset         = 1'b1;
        adc_valid     = 1'b0;
        adc_data      = '0;
        trigger_level = '0;
        arm           = 1'b0;
        read_busy     = 1'b0;
        read_CounterX = '0;
        for (int k = 0; k < c_DEPTH; k++) exp_mem[k] = 0;

        test_reset();
        test_level_trigger();
        test_arm_blocked();
        test_timeout();
        test_simultaneous();
        test_reset_mid_capture();
        test_gapped();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/adc_capture_buffer.md
ADC_CAPTURE_BUFFER -- requirements
Module: adc_capture_buffer

Interface
- REQ-001: Parameter ADDR_W, default 11, SHALL set the buffer address width; depth = 2^ADDR_W = 2048 samples.
- REQ-002: Parameter ROWS, default 120, SHALL set the plot height in pixels; CounterY range is 0..ROWS-1.
- REQ-003: Parameter TIMEOUT, default 65535, SHALL set the number of valid samples in ARMED before a forced trigger.
- REQ-004: clk  in  1  single system clock; all logic on its rising edge.
- REQ-005: reset  in  1  synchronous, active-high reset.
- REQ-006: adc_valid  in  1  one-cycle strobe qualifying adc_data.
- REQ-007: adc_data  in  14  unsigned ADC sample.
- REQ-008: trigger_level  in  14  unsigned rising-edge trigger threshold.
- REQ-009: arm  in  1  request to start a new capture.
- REQ-010: read_busy  in  1  high while the downstream drawer is sweeping CounterX; blocks buffer overwrite.
- REQ-011: read_CounterX  in  ADDR_W  sample read address from the drawer.
- REQ-012: CounterY  out  8  screen row for the addressed sample, registered.
- REQ-013: capture_done  out  1  high while the buffer holds a complete, stable capture.
- REQ-014: forced_trig  out  1  high when the held capture was started by timeout rather than a level crossing.

Function
- REQ-015: FSM states SHALL be IDLE, ARMED, CAPTURE, READY.
- REQ-016: IDLE -> ARMED when arm=1 and read_busy=0; arm SHALL be ignored while read_busy=1.
- REQ-017: READY -> ARMED under the same condition as REQ-016; capture_done SHALL drop on the cycle the FSM enters ARMED.
- REQ-018: prev_sample SHALL register adc_data on every adc_valid in any state.
- REQ-019: In ARMED, a trigger SHALL occur on an adc_valid where prev_sample < trigger_level and adc_data >= trigger_level.
- REQ-020: In ARMED, a timeout counter SHALL increment per adc_valid; a forced trigger SHALL occur on the adc_valid that brings it to TIMEOUT; the counter clears on entry to ARMED.
- REQ-021: A simultaneous level trigger and timeout SHALL count as a level trigger (forced_trig=0).
- REQ-022: On trigger, the triggering sample SHALL be written at address 0; the FSM enters CAPTURE with wr_addr=1.
- REQ-023: In CAPTURE, each adc_valid SHALL write adc_data at wr_addr and increment wr_addr; cycles without adc_valid write nothing.
- REQ-024: The write at wr_addr = 2^ADDR_W-1 SHALL move the FSM to READY and set capture_done=1 on the next cycle; wr_addr wraps to 0.
- REQ-025: In CAPTURE and ARMED, arm SHALL be ignored; no mid-capture restart.
- REQ-026: forced_trig SHALL be set or cleared at the trigger event and held until the next trigger.
- REQ-027: The read port SHALL be independent of the FSM; the read path is always active.
- REQ-028: Read latency SHALL be 2 cycles: cycle 1 synchronous memory read at read_CounterX; cycle 2 scale and register into CounterY.
- REQ-029: Scaling: y = min(sample[13:7], ROWS-1); CounterY = (ROWS-1) - y, zero-extended to 8 bits. Full-scale input maps to the top row 0; zero input maps to row ROWS-1.
- REQ-030: A read and a write to the same address in one cycle SHALL return the old contents (read-first).

Reset
- REQ-031: On reset, the FSM SHALL enter IDLE and clear wr_addr, the timeout counter, prev_sample, CounterY, capture_done and forced_trig; memory contents are not cleared.
- REQ-032: Reset asserted mid-CAPTURE SHALL abort the capture; capture_done stays 0 until a full new capture completes.

Verification
- VER-001: reset; trigger_level=8192; arm; samples 8000, 8100, 8300, then a ramp -> trigger on 8300 at addr 0; capture_done=1 after the 2048th valid write; forced_trig=0.
- VER-002: arm; constant adc_data=100 with level 8192 -> forced trigger on the 65535th valid sample; forced_trig=1; capture completes.
- VER-003: In READY, read_CounterX=0 with stored 8300 -> CounterY = 119-64 = 55 two cycles later; stored 16383 -> CounterY = 0; stored 0 -> CounterY = 119.
- VER-004: arm pulsed with read_busy=1 -> no state change and capture_done stays 1; arm pulsed after read_busy falls -> ARMED and capture_done=0.
- VER-005: reset pulsed at wr_addr=1000 in CAPTURE -> IDLE, capture_done=0; re-arm and capture -> full 2048-sample capture from addr 0.
- VER-006: adc_valid gapped (1 in 3 cycles) during CAPTURE -> exactly 2048 writes with no duplicates or skipped addresses.
